// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and decoder constants shared by ALU control and EX stage
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // 101 is unassigned; it still travels down the pipe, flagged as illegal
    localparam logic [2:0] ALU_ILLEGAL = 3'b101;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    function automatic logic is_illegal_ctrl(input logic [2:0] ctrl);
        return ctrl == ALU_ILLEGAL;
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// rtl/ex_alu_stage_if.sv - ID/EX input and EX/MEM output handshake bundle
interface ex_alu_stage_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
);
    logic              InValid__i;
    logic              InReady__o;
    logic [2:0]        ALUCtrl__i;
    logic [WIDTH-1:0]  OperandA__i;
    logic [WIDTH-1:0]  OperandB__i;
    logic [REG_AW-1:0] DestReg__i;
    logic              Flush__i;
    logic              OutValid__o;
    logic              OutReady__i;
    logic [WIDTH-1:0]  Result__o;
    logic              Zero__o;
    logic              Overflow__o;
    logic              IllegalOp__o;
    logic [REG_AW-1:0] DestReg__o;

    modport master (
        output InValid__i, ALUCtrl__i, OperandA__i, OperandB__i, DestReg__i, Flush__i, OutReady__i,
        input  InReady__o, OutValid__o, Result__o, Zero__o, Overflow__o, IllegalOp__o, DestReg__o
    );

    modport slave (
        input  InValid__i, ALUCtrl__i, OperandA__i, OperandB__i, DestReg__i, Flush__i, OutReady__i,
        output InReady__o, OutValid__o, Result__o, Zero__o, Overflow__o, IllegalOp__o, DestReg__o
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational MIPS ALU: result, zero, signed overflow, illegal-op flag
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        result  = '0;
        ovf     = 1'b0;
        illegal = is_illegal_ctrl(ctrl);
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result = sum;
                ovf    = ovf_add;
            end
            ALU_SUB: begin
                result = diff;
                ovf    = ovf_sub;
            end
            // Correcting the difference sign with overflow keeps SLT right at the extremes
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - EX stage: ID/EX slot, ALU, EX/MEM slot with valid/ready and flush
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic           Clk__i,
    input  logic           Reset_n__i,
    ex_alu_stage_if.slave  bus
);
    logic              s1_valid_q, s1_valid_d;
    logic [2:0]        s1_ctrl_q, s1_ctrl_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [REG_AW-1:0] s1_dest_q, s1_dest_d;

    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s2_result_q, s2_result_d;
    logic              s2_zero_q, s2_zero_d;
    logic              s2_ovf_q, s2_ovf_d;
    logic              s2_ill_q, s2_ill_d;
    logic [REG_AW-1:0] s2_dest_q, s2_dest_d;

    logic              s2_free;
    logic              advance;
    logic              in_xfer;
    logic              out_xfer;

    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;
    logic              alu_ovf;
    logic              alu_ill;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .ctrl    (s1_ctrl_q),
        .a       (s1_a_q),
        .b       (s1_b_q),
        .result  (alu_result),
        .zero    (alu_zero),
        .ovf     (alu_ovf),
        .illegal (alu_ill)
    );

    always_comb begin
        s2_free  = !s2_valid_q || bus.OutReady__i;
        advance  = s1_valid_q && s2_free;
        in_xfer  = bus.InValid__i && (!s1_valid_q || s2_free);
        out_xfer = s2_valid_q && bus.OutReady__i;

        s1_valid_d  = s1_valid_q;
        s1_ctrl_d   = s1_ctrl_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_dest_d   = s1_dest_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_ovf_d    = s2_ovf_q;
        s2_ill_d    = s2_ill_q;
        s2_dest_d   = s2_dest_q;

        if (in_xfer) begin
            s1_ctrl_d = bus.ALUCtrl__i;
            s1_a_d    = bus.OperandA__i;
            s1_b_d    = bus.OperandB__i;
            s1_dest_d = bus.DestReg__i;
        end
        if (advance) begin
            s2_result_d = alu_result;
            s2_zero_d   = alu_zero;
            s2_ovf_d    = alu_ovf;
            s2_ill_d    = alu_ill;
            s2_dest_d   = s1_dest_q;
        end

        // Flush only kills valid bits; data may go stale since outputs are valid-qualified
        if (bus.Flush__i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid_d = 1'b1;
            end else if (advance) begin
                s1_valid_d = 1'b0;
            end
            if (advance) begin
                s2_valid_d = 1'b1;
            end else if (out_xfer) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk__i or negedge Reset_n__i) begin
        if (!Reset_n__i) begin
            s1_valid_q  <= 1'b0;
            s1_ctrl_q   <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_dest_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_ill_q    <= 1'b0;
            s2_dest_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_dest_q   <= s1_dest_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_ill_q    <= s2_ill_d;
            s2_dest_q   <= s2_dest_d;
        end
    end

    assign bus.InReady__o   = !s1_valid_q || s2_free;
    assign bus.OutValid__o  = s2_valid_q;
    assign bus.Result__o    = s2_result_q;
    assign bus.Zero__o      = s2_zero_q;
    assign bus.Overflow__o  = s2_ovf_q;
    assign bus.IllegalOp__o = s2_ill_q;
    assign bus.DestReg__o   = s2_dest_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - directed and random checks of ex_alu_stage against a queue model
module tb_ex_alu_stage;

    logic clk;
    logic rst_n;

    ex_alu_stage_if #(.WIDTH(32), .REG_AW(5)) bus ();

    ex_alu_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .Clk__i     (clk),
        .Reset_n__i (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [4:0]  dest;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   accepts   = 0;
    int   delivered = 0;
    bit   last_acc  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t ref_alu(input logic [2:0] c, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] d);
        exp_t   e;
        longint sa, sb, s;
        sa    = $signed(a);
        sb    = $signed(b);
        e.res = 32'h0;
        e.ovf = 1'b0;
        e.ill = 1'b0;
        e.dest = d;
        e.acc = 0;
        case (c)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = ~(a | b);
            3'd2, 3'd6: begin
                s     = (c == 3'd2) ? sa + sb : sa - sb;
                e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd7: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    task automatic tick();
        bit   in_x, out_x;
        exp_t it;
        #1;
        chk("in_ready", bus.InReady__o, (q.size() < 2) || bus.OutReady__i);
        chk("out_valid", bus.OutValid__o, (q.size() > 0) && (cyc > q[0].acc));
        if (bus.OutValid__o && q.size() > 0) begin
            chk("result", bus.Result__o, q[0].res);
            chk("zero", bus.Zero__o, q[0].zero);
            chk("overflow", bus.Overflow__o, q[0].ovf);
            chk("illegal", bus.IllegalOp__o, q[0].ill);
            chk("dest", bus.DestReg__o, q[0].dest);
        end
        in_x  = bus.InValid__i && bus.InReady__o;
        out_x = bus.OutValid__o && bus.OutReady__i;
        it    = ref_alu(bus.ALUCtrl__i, bus.OperandA__i, bus.OperandB__i, bus.DestReg__i);
        @(posedge clk);
        cyc++;
        last_acc = in_x && !bus.Flush__i;
        if (out_x && q.size() > 0) begin
            q.delete(0);
            delivered++;
        end
        if (bus.Flush__i) begin
            q.delete();
        end else if (in_x) begin
            it.acc = cyc;
            q.push_back(it);
            accepts++;
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        bus.InValid__i  = 1'b1;
        bus.ALUCtrl__i  = c;
        bus.OperandA__i = a;
        bus.OperandB__i = b;
        bus.DestReg__i  = d;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic z,
                              input logic o, input logic i);
        chk({tag, "_valid"}, bus.OutValid__o, 1'b1);
        chk({tag, "_res"}, bus.Result__o, res);
        chk({tag, "_zero"}, bus.Zero__o, z);
        chk({tag, "_ovf"}, bus.Overflow__o, o);
        chk({tag, "_ill"}, bus.IllegalOp__o, i);
    endtask

    task automatic single_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] res, input logic z,
                             input logic o, input logic i);
        set_op(c, a, b, 5'd9);
        tick();
        bus.InValid__i = 1'b0;
        tick();
        expect_out(tag, res, z, o, i);
        tick();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, a0, d0, guard;
        rst_n           = 1'b0;
        bus.InValid__i  = 1'b0;
        bus.ALUCtrl__i  = 3'd0;
        bus.OperandA__i = 32'h0;
        bus.OperandB__i = 32'h0;
        bus.DestReg__i  = 5'd0;
        bus.Flush__i    = 1'b0;
        bus.OutReady__i = 1'b1;

        #2;
        chk("rst_out_valid", bus.OutValid__o, 1'b0);
        chk("rst_result", bus.Result__o, 32'h0);
        chk("rst_flags", {bus.Zero__o, bus.Overflow__o, bus.IllegalOp__o}, 3'b000);
        chk("rst_dest", bus.DestReg__o, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.InReady__o, 1'b1);

        // Reset mid-stream with both slots occupied
        bus.OutReady__i = 1'b0;
        set_op(3'd2, 32'd1, 32'd2, 5'd3);
        tick();
        set_op(3'd1, 32'hF0, 32'h0F, 5'd4);
        tick();
        bus.InValid__i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_out_valid", bus.OutValid__o, 1'b0);
        chk("mid_rst_result", bus.Result__o, 32'h0);
        chk("mid_rst_dest", bus.DestReg__o, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.OutReady__i = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.InReady__o, 1'b1);
        chk("mid_rst_no_output", bus.OutValid__o, 1'b0);

        // Streaming ADD, SUB, SLT
        set_op(3'd2, 32'd5, 32'd7, 5'd1);
        tick();
        set_op(3'd6, 32'd3, 32'd3, 5'd2);
        tick();
        expect_out("stream_add", 32'd12, 1'b0, 1'b0, 1'b0);
        set_op(3'd7, 32'hFFFF_FFFF, 32'd1, 5'd3);
        tick();
        expect_out("stream_sub", 32'd0, 1'b1, 1'b0, 1'b0);
        bus.InValid__i = 1'b0;
        tick();
        expect_out("stream_slt", 32'd1, 1'b0, 1'b0, 1'b0);
        tick();

        single_op("ovf_add", 3'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single_op("ovf_sub", 3'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        single_op("slt_min", 3'd7, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        single_op("illegal", 3'b101, 32'hFFFF, 32'hFFFF, 32'd0, 1'b1, 1'b0, 1'b1);
        single_op("nor_zero", 3'd4, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Backpressure: four ops, downstream stalled for five cycles
        bus.OutReady__i = 1'b0;
        k  = 0;
        a0 = accepts;
        d0 = delivered;
        repeat (5) begin
            if (k < 4) set_op(3'd2, 32'(100 * (k + 1)), 32'(k), 5'(10 + k));
            else bus.InValid__i = 1'b0;
            tick();
            if (last_acc) k++;
        end
        chk("bp_accepts_stalled", 32'(accepts - a0), 32'd2);
        bus.OutReady__i = 1'b1;
        guard = 0;
        while ((k < 4 || q.size() > 0) && guard < 20) begin
            if (k < 4) set_op(3'd2, 32'(100 * (k + 1)), 32'(k), 5'(10 + k));
            else bus.InValid__i = 1'b0;
            tick();
            if (last_acc) k++;
            guard++;
        end
        chk("bp_timeout", guard < 20, 1'b1);
        chk("bp_delivered", 32'(delivered - d0), 32'd4);

        // Flush with both slots full and a concurrent in- and out-transfer
        bus.OutReady__i = 1'b0;
        guard = 0;
        while (q.size() < 2 && guard < 10) begin
            set_op(3'd3, 32'hA5A5_0000, 32'(guard), 5'd7);
            tick();
            guard++;
        end
        chk("flush_fill", q.size(), 32'd2);
        d0 = delivered;
        bus.OutReady__i = 1'b1;
        bus.Flush__i    = 1'b1;
        set_op(3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 5'd8);
        tick();
        bus.Flush__i   = 1'b0;
        bus.InValid__i = 1'b0;
        chk("flush_out_valid", bus.OutValid__o, 1'b0);
        chk("flush_out_xfer_done", 32'(delivered - d0), 32'd1);
        single_op("post_flush", 3'd2, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model
        repeat (400) begin
            set_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom));
            bus.InValid__i  = ($urandom_range(0, 3) != 0);
            bus.OutReady__i = ($urandom_range(0, 2) != 0);
            bus.Flush__i    = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus.InValid__i  = 1'b0;
        bus.Flush__i    = 1'b0;
        bus.OutReady__i = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("drain_timeout", guard < 10, 1'b1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
